// File: rtl/head_gbus_out_arbiter.sv
// head_gbus_out_arbiter
//   Merges the per-core GBUS write outports of a head core array onto one
//   shared GBUS write port. Cores cannot be stalled, so each core owns a small
//   FIFO. A round-robin arbiter drains the FIFOs into a single registered
//   output stage that uses a valid/ready handshake.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_addr_array    N*AW  per-core write address (core i at [i*AW +: AW])
//   in_wen_array     N     per-core write strobe, one word per cycle per core
//   in_wdata_array   N*DW  per-core write data   (core i at [i*DW +: DW])
//   out_gbus_addr    AW    merged address
//   out_gbus_wen     1     merged write valid
//   out_gbus_wdata   DW    merged data
//   out_gbus_ready   1     downstream accepts the word when high with wen
//   ovf_clear        1     pulse, clears all overflow flags
//   ovf_flag         N     sticky per-core "a word was dropped" flag
//   idle             1     all FIFOs empty and output stage empty
module head_gbus_out_arbiter #(
  parameter int HEAD_CORE_NUM   = 4,
  parameter int GBUS_ADDR_WIDTH = 16,
  parameter int GBUS_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [HEAD_CORE_NUM*GBUS_ADDR_WIDTH-1:0] in_addr_array,
  input  logic [HEAD_CORE_NUM-1:0]                 in_wen_array,
  input  logic [HEAD_CORE_NUM*GBUS_DATA_WIDTH-1:0] in_wdata_array,
  output logic [GBUS_ADDR_WIDTH-1:0]               out_gbus_addr,
  output logic                                     out_gbus_wen,
  output logic [GBUS_DATA_WIDTH-1:0]               out_gbus_wdata,
  input  logic                                     out_gbus_ready,
  input  logic                                     ovf_clear,
  output logic [HEAD_CORE_NUM-1:0]                 ovf_flag,
  output logic                                     idle
);

  localparam int N  = HEAD_CORE_NUM;
  localparam int AW = GBUS_ADDR_WIDTH;
  localparam int DW = GBUS_DATA_WIDTH;
  localparam int EW = AW + DW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(N);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [RW:0] N_CNT    = (RW+1)'(N);

  logic [EW-1:0] mem_q    [N][FIFO_DEPTH];
  logic [EW-1:0] mem_d    [N][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [N];
  logic [PW-1:0] wr_ptr_d [N];
  logic [PW-1:0] rd_ptr_q [N];
  logic [PW-1:0] rd_ptr_d [N];
  logic [PW:0]   cnt_q    [N];
  logic [PW:0]   cnt_d    [N];
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [N-1:0]  ovf_q, ovf_d;
  logic          idle_q, idle_d;

  logic          stage_load_s;
  logic          grant_valid_s;
  logic [RW-1:0] grant_idx_s;
  logic [RW:0]   cand_s;
  logic [RW:0]   rr_next_s;
  logic [N-1:0]  pop_s, push_s, drop_s;
  logic [EW-1:0] head_s;
  logic          any_cnt_s;

  assign stage_load_s = !out_valid_q || out_gbus_ready;

  // Round-robin search starting at rr_ptr; first non-empty FIFO wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = {RW{1'b0}};
    cand_s        = {(RW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (RW+1)'(k);
      if (cand_s >= N_CNT) begin
        cand_s = cand_s - N_CNT;
      end else begin
        cand_s = cand_s;
      end
      if (stage_load_s && !grant_valid_s && (cnt_q[cand_s[RW-1:0]] != {(PW+1){1'b0}})) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = cand_s[RW-1:0];
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Per-core FIFO bookkeeping; a full FIFO still accepts when popped this cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pop_s    = {N{1'b0}};
    push_s   = {N{1'b0}};
    drop_s   = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      pop_s[i]  = grant_valid_s && (grant_idx_s == RW'(i));
      push_s[i] = in_wen_array[i] && ((cnt_q[i] != FULL_CNT) || pop_s[i]);
      drop_s[i] = in_wen_array[i] && !push_s[i];
      if (push_s[i]) begin
        mem_d[i][wr_ptr_q[i]] = {in_addr_array[i*AW +: AW], in_wdata_array[i*DW +: DW]};
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + (PW+1)'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - (PW+1)'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Output stage, round-robin pointer, overflow flags and idle.
  always_comb begin
    head_s      = mem_q[grant_idx_s][rd_ptr_q[grant_idx_s]];
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    rr_next_s   = {1'b0, grant_idx_s} + (RW+1)'(1);
    if (stage_load_s) begin
      out_valid_d = grant_valid_s;
      if (grant_valid_s) begin
        out_addr_d = head_s[EW-1:DW];
        out_data_d = head_s[DW-1:0];
      end else begin
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    if (grant_valid_s) begin
      if (rr_next_s == N_CNT) begin
        rr_ptr_d = {RW{1'b0}};
      end else begin
        rr_ptr_d = rr_next_s[RW-1:0];
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    // A drop in the same cycle as a clear must leave the flag set.
    if (ovf_clear) begin
      ovf_d = drop_s;
    end else begin
      ovf_d = ovf_q | drop_s;
    end
    any_cnt_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      any_cnt_s = any_cnt_s | (cnt_d[i] != {(PW+1){1'b0}});
    end
    idle_d = !any_cnt_s && !out_valid_d;
  end

  // State registers; reset discards every buffered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= {PW{1'b0}};
        rd_ptr_q[i] <= {PW{1'b0}};
        cnt_q[i]    <= {(PW+1){1'b0}};
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= {EW{1'b0}};
        end
      end
      rr_ptr_q    <= {RW{1'b0}};
      out_valid_q <= 1'b0;
      out_addr_q  <= {AW{1'b0}};
      out_data_q  <= {DW{1'b0}};
      ovf_q       <= {N{1'b0}};
      idle_q      <= 1'b1;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
      idle_q      <= idle_d;
    end
  end

  assign out_gbus_wen   = out_valid_q;
  assign out_gbus_addr  = out_addr_q;
  assign out_gbus_wdata = out_data_q;
  assign ovf_flag       = ovf_q;
  assign idle           = idle_q;

endmodule

// File: tb/tb_head_gbus_out_arbiter.sv
// Self-checking bench for head_gbus_out_arbiter: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_head_gbus_out_arbiter;
  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int D  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NC*AW-1:0]  in_addr_array = '0;
  logic [NC-1:0]     in_wen_array = '0;
  logic [NC*DW-1:0]  in_wdata_array = '0;
  logic [AW-1:0]     out_gbus_addr;
  logic              out_gbus_wen;
  logic [DW-1:0]     out_gbus_wdata;
  logic              out_gbus_ready = 1'b1;
  logic              ovf_clear = 1'b0;
  logic [NC-1:0]     ovf_flag;
  logic              idle;

  int tests = 0;
  int fails = 0;

  head_gbus_out_arbiter #(
    .HEAD_CORE_NUM(NC), .GBUS_ADDR_WIDTH(AW), .GBUS_DATA_WIDTH(DW), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_addr_array(in_addr_array), .in_wen_array(in_wen_array), .in_wdata_array(in_wdata_array),
    .out_gbus_addr(out_gbus_addr), .out_gbus_wen(out_gbus_wen), .out_gbus_wdata(out_gbus_wdata),
    .out_gbus_ready(out_gbus_ready), .ovf_clear(ovf_clear), .ovf_flag(ovf_flag), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one queue per core, a single output slot and a rotating start index.
  logic [AW+DW-1:0] mq [NC][$];
  bit               m_valid = 1'b0;
  logic [AW-1:0]    m_addr = '0;
  logic [DW-1:0]    m_data = '0;
  logic [NC-1:0]    m_ovf = '0;
  bit               m_idle = 1'b1;
  int               m_rr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) mq[i].delete();
      m_valid = 1'b0; m_addr = '0; m_data = '0; m_ovf = '0; m_idle = 1'b1; m_rr = 0;
    end else begin
      int g;
      logic [AW+DW-1:0] w;
      g = -1;
      if (!m_valid || out_gbus_ready) begin
        for (int k = 0; k < NC; k++) begin
          if (g < 0 && mq[(m_rr + k) % NC].size() > 0) g = (m_rr + k) % NC;
        end
        if (g >= 0) begin
          w = mq[g].pop_front();
          m_addr = w[AW+DW-1:DW]; m_data = w[DW-1:0];
          m_valid = 1'b1; m_rr = (g + 1) % NC;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (ovf_clear) m_ovf = '0;
      for (int i = 0; i < NC; i++) begin
        if (in_wen_array[i]) begin
          if (mq[i].size() < D) mq[i].push_back({in_addr_array[i*AW +: AW], in_wdata_array[i*DW +: DW]});
          else m_ovf[i] = 1'b1;
        end
      end
      m_idle = !m_valid;
      for (int i = 0; i < NC; i++) if (mq[i].size() != 0) m_idle = 1'b0;
    end
  end

  // Every cycle out of reset, outputs must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_wen", out_gbus_wen, m_valid);
      check("m_ovf", ovf_flag, m_ovf);
      check("m_idle", idle, m_idle);
      if (m_valid) begin
        check("m_addr", out_gbus_addr, m_addr);
        check("m_data", out_gbus_wdata, m_data);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_wen_array[c] = 1'b1;
    in_addr_array[c*AW +: AW] = a;
    in_wdata_array[c*DW +: DW] = d;
  endtask

  initial begin
    int ids[$];
    cyc(); cyc();
    check("rst_wen", out_gbus_wen, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_ovf", ovf_flag, 4'h0);
    check("rst_addr", out_gbus_addr, 16'h0);
    rst_n = 1'b1;
    cyc();

    // All cores write in one cycle: grants 0..N-1 on consecutive cycles.
    for (int i = 0; i < NC; i++) drive(i, 16'(i), 32'hC0 + 32'(i));
    cyc(); in_wen_array = '0;
    check("all_idle_drop", idle, 1'b0);
    cyc();
    for (int k = 0; k < NC; k++) begin
      check("all_wen", out_gbus_wen, 1'b1);
      check("all_data", out_gbus_wdata, 32'hC0 + 32'(k));
      cyc();
    end
    check("all_done", out_gbus_wen, 1'b0);

    // Single word from core 2: 2-cycle latency, one cycle of wen, idle returns.
    drive(2, 16'h10, 32'hAB);
    cyc(); in_wen_array = '0;
    check("one_idle0", idle, 1'b0);
    check("one_wen_early", out_gbus_wen, 1'b0);
    cyc();
    check("one_wen", out_gbus_wen, 1'b1);
    check("one_addr", out_gbus_addr, 16'h10);
    check("one_data", out_gbus_wdata, 32'hAB);
    cyc();
    check("one_wen_off", out_gbus_wen, 1'b0);
    check("one_idle1", idle, 1'b1);

    // Backpressure: word 0 holds, then three words on consecutive cycles.
    out_gbus_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(0, 16'h100 + 16'(j), 32'h100 + 32'(j));
      cyc();
      if (j >= 1) check("hold_w0", out_gbus_wdata, 32'h100);
    end
    in_wen_array = '0;
    cyc(); check("hold_addr", out_gbus_addr, 16'h100);
    cyc(); check("hold_wen", out_gbus_wen, 1'b1);
    out_gbus_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check("hold_seq_wen", out_gbus_wen, 1'b1);
      check("hold_seq", out_gbus_wdata, 32'h100 + 32'(j));
      cyc();
    end
    check("hold_end", out_gbus_wen, 1'b0);

    // Overflow: DEPTH+3 words into core 1 with ready low, DEPTH+1 survive.
    out_gbus_ready = 1'b0;
    for (int j = 0; j < D + 3; j++) begin
      drive(1, 16'h200 + 16'(j), 32'h200 + 32'(j));
      cyc();
    end
    in_wen_array = '0;
    check("ovf_set", ovf_flag, 4'b0010);
    ovf_clear = 1'b1; cyc(); ovf_clear = 1'b0;
    check("ovf_clr", ovf_flag, 4'b0000);
    out_gbus_ready = 1'b1;
    for (int j = 0; j < D + 1; j++) begin
      check("ovf_drain", out_gbus_wdata, 32'h200 + 32'(j));
      cyc();
    end
    check("ovf_end", out_gbus_wen, 1'b0);

    // Cores 0 and 3 stream together: grants alternate, starting at core 3.
    for (int t = 0; t < 20; t++) begin
      if (t < 6) begin
        drive(0, 16'h300 + 16'(t), 32'h000 + 32'(t));
        drive(3, 16'h380 + 16'(t), 32'h300 + 32'(t));
      end else begin
        in_wen_array = '0;
      end
      cyc();
      if (out_gbus_wen) ids.push_back(int'(out_gbus_wdata[11:8]));
    end
    check("stream_cnt", 64'(ids.size()), 64'd12);
    check("stream_first", 64'(ids[0]), 64'd3);
    for (int j = 1; j < 8; j++) check("stream_alt", 64'(ids[j]), (ids[j-1] == 0) ? 64'd3 : 64'd0);

    // Reset with words buffered and an overflow pending.
    out_gbus_ready = 1'b0;
    for (int j = 0; j < 7; j++) begin
      drive(0, 16'h400 + 16'(j), 32'h400 + 32'(j));
      cyc();
    end
    in_wen_array = '0;
    check("pre_rst_ovf", ovf_flag, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wen", out_gbus_wen, 1'b0);
    check("mid_rst_idle", idle, 1'b1);
    check("mid_rst_ovf", ovf_flag, 4'b0000);
    cyc(); rst_n = 1'b1; out_gbus_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc();
      check("post_rst_wen", out_gbus_wen, 1'b0);
      check("post_rst_idle", idle, 1'b1);
    end

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NC; i++) begin
        in_wen_array[i] = ($urandom_range(0, 99) < 30);
        in_addr_array[i*AW +: AW] = 16'($urandom);
        in_wdata_array[i*DW +: DW] = $urandom;
      end
      out_gbus_ready = ($urandom_range(0, 3) != 0);
      ovf_clear = ($urandom_range(0, 31) == 0);
      cyc();
    end
    in_wen_array = '0; ovf_clear = 1'b0; out_gbus_ready = 1'b1;
    for (int t = 0; t < 30; t++) cyc();
    check("final_idle", idle, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
